bsg_zynq_accel_combine: RTL and testbench

BSG_ZYNQ_ACCEL_COMBINE -- requirements
Module: bsg_zynq_accel_combine

---
 rtl/bsg_zynq_accel_combine.sv | 110 +++++++++++
 tb/tb_bsg_zynq_accel_combine.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_zynq_accel_combine.sv
// rtl/bsg_zynq_accel_combine.sv - per-lane combine/accumulate of FIFO heads with AW address snoop
// Each output lane reduces fan_in_p input heads per beat and folds accum_len beats into one result.
module bsg_zynq_accel_combine #(
  parameter int width_p      = 32,
  parameter int num_out_p    = 2,
  parameter int fan_in_p     = 2,
  parameter int addr_width_p = 6,
  parameter int cnt_width_p  = 32
) (
  input  logic                                          aclk,
  input  logic                                          reset_i,
  input  logic [num_out_p*fan_in_p-1:0][width_p-1:0]    in_data_i,
  input  logic [num_out_p*fan_in_p-1:0]                 in_v_i,
  output logic [num_out_p*fan_in_p-1:0]                 in_yumi_o,
  output logic [num_out_p-1:0][width_p-1:0]             out_data_o,
  output logic [num_out_p-1:0]                          out_v_o,
  input  logic [num_out_p-1:0]                          out_ready_i,
  input  logic [1:0]                                    mode_i,
  input  logic [7:0]                                    accum_len_i,
  output logic [num_out_p-1:0][cnt_width_p-1:0]         beat_cnt_o,
  input  logic [addr_width_p-1:0]                       aw_addr_i,
  input  logic                                          aw_v_i,
  input  logic                                          aw_ready_i,
  output logic [addr_width_p-1:0]                       last_addr_o
);

  typedef enum logic [1:0] {op_add = 2'd0, op_sub = 2'd1, op_xor = 2'd2, op_max = 2'd3} op_e;

  localparam logic [cnt_width_p-1:0] cnt_one = cnt_width_p'(1);

  for (genvar k = 0; k < num_out_p; k++) begin : lane
    logic [width_p-1:0]     acc_r, out_data_r, beat_val, next_acc;
    logic [7:0]             idx_r, len_r, cur_len;
    op_e                    mode_r, cur_mode;
    logic                   out_v_r, all_v, last_beat, accept;
    logic [cnt_width_p-1:0] cnt_r;

    // Mode and length come straight from the inputs on the first beat, then from the latch.
    always_comb begin
      cur_mode  = (idx_r == 8'd0) ? op_e'(mode_i) : mode_r;
      cur_len   = (idx_r == 8'd0) ? ((accum_len_i == 8'd0) ? 8'd1 : accum_len_i) : len_r;
      all_v     = &in_v_i[k*fan_in_p +: fan_in_p];
      last_beat = (idx_r == cur_len - 8'd1);
      accept    = !reset_i && all_v && (!out_v_r || out_ready_i[k] || !last_beat);
      beat_val  = in_data_i[k*fan_in_p];
      for (int j = 1; j < fan_in_p; j++) begin
        case (cur_mode)
          op_add:  beat_val = beat_val + in_data_i[k*fan_in_p+j];
          op_sub:  beat_val = beat_val - in_data_i[k*fan_in_p+j];
          op_xor:  beat_val = beat_val ^ in_data_i[k*fan_in_p+j];
          default: beat_val = (in_data_i[k*fan_in_p+j] > beat_val) ? in_data_i[k*fan_in_p+j] : beat_val;
        endcase
      end
      next_acc = beat_val;
      if (idx_r != 8'd0) begin
        // sub beats already carry input0 minus the rest, so folding is a plain add
        case (cur_mode)
          op_add, op_sub: next_acc = acc_r + beat_val;
          op_xor:         next_acc = acc_r ^ beat_val;
          default:        next_acc = (beat_val > acc_r) ? beat_val : acc_r;
        endcase
      end
    end

    always_ff @(posedge aclk) begin
      if (reset_i) begin
        acc_r      <= '0;
        out_data_r <= '0;
        out_v_r    <= 1'b0;
        idx_r      <= 8'd0;
        len_r      <= 8'd1;
        mode_r     <= op_add;
        cnt_r      <= '0;
      end else begin
        if (out_v_r && out_ready_i[k]) begin
          out_v_r <= 1'b0;
          cnt_r   <= cnt_r + cnt_one;
        end
        if (accept) begin
          if (idx_r == 8'd0) begin
            mode_r <= cur_mode;
            len_r  <= cur_len;
          end
          acc_r <= next_acc;
          if (last_beat) begin
            out_data_r <= next_acc;
            out_v_r    <= 1'b1;
            idx_r      <= 8'd0;
          end else begin
            idx_r <= idx_r + 8'd1;
          end
        end
      end
    end

    assign in_yumi_o[k*fan_in_p +: fan_in_p] = {fan_in_p{accept}};
    assign out_v_o[k]    = out_v_r;
    assign out_data_o[k] = out_data_r;
    assign beat_cnt_o[k] = cnt_r;
  end

  always_ff @(posedge aclk) begin
    if (reset_i) begin
      last_addr_o <= '0;
    end else if (aw_v_i && aw_ready_i) begin
      last_addr_o <= aw_addr_i;
    end
  end

endmodule

// File: tb/tb_bsg_zynq_accel_combine.sv
// tb/tb_bsg_zynq_accel_combine.sv - self-checking bench for bsg_zynq_accel_combine
// Directed vector table and corner sequences, then random traffic against a group-level model.
module tb_bsg_zynq_accel_combine;

  logic             aclk = 1'b0;
  logic             reset;
  logic [3:0][31:0] in_data;
  logic [3:0]       in_v, in_yumi;
  logic [1:0][31:0] out_data;
  logic [1:0]       out_v, out_ready;
  logic [1:0]       mode;
  logic [7:0]       accum_len;
  logic [1:0][31:0] beat_cnt;
  logic [5:0]       aw_addr, last_addr;
  logic             aw_v, aw_ready;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  bsg_zynq_accel_combine dut (
    .aclk(aclk), .reset_i(reset), .in_data_i(in_data), .in_v_i(in_v), .in_yumi_o(in_yumi),
    .out_data_o(out_data), .out_v_o(out_v), .out_ready_i(out_ready), .mode_i(mode),
    .accum_len_i(accum_len), .beat_cnt_o(beat_cnt), .aw_addr_i(aw_addr), .aw_v_i(aw_v),
    .aw_ready_i(aw_ready), .last_addr_o(last_addr)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic lane0(input logic [31:0] a, input logic [31:0] b);
    in_data[0] = a;
    in_data[1] = b;
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[6];

  // group-level reference: raw inputs of the open group per lane, reduced only at completion
  logic [31:0] ga[2][4];
  logic [31:0] gb[2][4];
  int          m_n[2];
  int          m_len[2];
  logic [1:0]  m_mode[2];
  logic        m_pend[2];
  logic [31:0] m_val[2];
  logic [31:0] m_cnt[2];

  function automatic logic [31:0] group_result(int k);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < m_n[k]; i++) begin
      case (m_mode[k])
        2'd0: r = r + ga[k][i] + gb[k][i];
        2'd1: r = r + ga[k][i] - gb[k][i];
        2'd2: r = r ^ ga[k][i] ^ gb[k][i];
        default: begin
          if (ga[k][i] > r) r = ga[k][i];
          if (gb[k][i] > r) r = gb[k][i];
        end
      endcase
    end
    return r;
  endfunction

  initial begin
    vecs[0] = '{2'd0, 32'd5,         32'd7,  32'd12};
    vecs[1] = '{2'd0, 32'hFFFFFFFF,  32'd2,  32'd1};
    vecs[2] = '{2'd1, 32'd3,         32'd5,  32'hFFFFFFFE};
    vecs[3] = '{2'd3, 32'h80000000,  32'd1,  32'h80000000};
    vecs[4] = '{2'd2, 32'h000000F0,  32'hFF, 32'h0000000F};
    vecs[5] = '{2'd3, 32'd1, 32'h80000000,   32'h80000000};

    reset = 1'b1; in_data = '0; in_v = 4'hF; out_ready = 2'b00; mode = 2'd0; accum_len = 8'd1;
    aw_addr = 6'h2A; aw_v = 1'b1; aw_ready = 1'b1;
    nxt(); nxt();
    chk("reset_yumi", in_yumi, 4'h0);
    chk("reset_out_v", out_v, 2'b00);
    chk("reset_out_data", out_data, 64'd0);
    chk("reset_beat_cnt", beat_cnt, 64'd0);
    chk("reset_last_addr", last_addr, 6'd0);

    reset = 1'b0; in_v = 4'h0; aw_v = 1'b0; out_ready = 2'b11;
    nxt();
    for (int i = 0; i < 6; i++) begin
      lane0(vecs[i].a, vecs[i].b);
      in_v = 4'b0011; mode = vecs[i].mode; accum_len = 8'd1;
      #1 chk($sformatf("vec%0d_yumi", i), in_yumi, 4'b0011);
      nxt();
      in_v = 4'b0000;
      #1 chk($sformatf("vec%0d_out_v", i), out_v[0], 1'b1);
      chk($sformatf("vec%0d_out_data", i), out_data[0], vecs[i].exp);
      chk($sformatf("vec%0d_beat_cnt", i), beat_cnt[0], 64'(i));
    end
    nxt();
    chk("vec_cnt_final", beat_cnt[0], 64'd6);
    chk("vec_out_v_clear", out_v[0], 1'b0);

    // accumulate over three beats; mode change mid-group must be ignored
    lane0(32'd1, 32'd2); in_v = 4'b0011; mode = 2'd0; accum_len = 8'd3;
    #1 chk("acc_yumi0", in_yumi, 4'b0011);
    nxt();
    mode = 2'd2; lane0(32'd3, 32'd4);
    #1 chk("acc_no_out1", out_v[0], 1'b0);
    nxt();
    lane0(32'd5, 32'd6);
    #1 chk("acc_no_out2", out_v[0], 1'b0);
    nxt();
    in_v = 4'b0000;
    #1 chk("acc_out_v", out_v[0], 1'b1);
    chk("acc_out_data", out_data[0], 32'd21);
    nxt();
    chk("acc_cnt", beat_cnt[0], 64'd7);

    // backpressure with lane 1 running independently
    mode = 2'd0; accum_len = 8'd1; out_ready = 2'b10;
    lane0(32'd10, 32'd20); in_data[2] = 32'd100; in_data[3] = 32'd1; in_v = 4'b0011;
    #1 chk("bp_first_yumi", in_yumi, 4'b0011);
    nxt();
    lane0(32'd1, 32'd1); in_v = 4'b1111;
    #1 chk("bp_out_v", out_v[0], 1'b1);
    chk("bp_out_data", out_data[0], 32'd30);
    chk("bp_stall_yumi", in_yumi, 4'b1100);
    nxt();
    #1 chk("bp_hold_data", out_data[0], 32'd30);
    chk("bp_hold_yumi", in_yumi, 4'b1100);
    chk("bp_lane1_out", out_data[1], 32'd101);
    out_ready = 2'b11;
    #1 chk("bp_release_yumi", in_yumi, 4'b1111);
    nxt();
    lane0(32'd2, 32'd2); in_v = 4'b0011;
    #1 chk("bb_out_v1", out_v[0], 1'b1);
    chk("bb_out_data1", out_data[0], 32'd2);
    chk("bb_yumi", in_yumi, 4'b0011);
    nxt();
    in_v = 4'b0000;
    #1 chk("bb_out_v2", out_v[0], 1'b1);
    chk("bb_out_data2", out_data[0], 32'd4);
    nxt();
    chk("bb_clear", out_v[0], 1'b0);
    chk("bb_cnt", beat_cnt[0], 64'd10);

    // reset with a pending result and a partial group
    out_ready = 2'b10; accum_len = 8'd1; lane0(32'd1, 32'd1); in_v = 4'b0011;
    nxt();
    accum_len = 8'd3;
    #1 chk("rst_pend_out_v", out_v[0], 1'b1);
    chk("rst_beat0_yumi", in_yumi, 4'b0011);
    nxt();
    #1 chk("rst_beat1_yumi", in_yumi, 4'b0011);
    nxt();
    reset = 1'b1;
    #1 chk("rst_no_yumi", in_yumi, 4'b0000);
    nxt();
    chk("rst_out_v", out_v, 2'b00);
    chk("rst_beat_cnt", beat_cnt, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    reset = 1'b0; out_ready = 2'b11;
    #1 chk("rst_restart_yumi", in_yumi, 4'b0011);
    nxt(); nxt();
    #1 chk("rst_restart_partial", out_v[0], 1'b0);
    nxt();
    in_v = 4'b0000;
    #1 chk("rst_restart_out_v", out_v[0], 1'b1);
    chk("rst_restart_data", out_data[0], 32'd6);
    nxt();

    // write-address snoop
    aw_v = 1'b1; aw_ready = 1'b0; aw_addr = 6'h10;
    nxt();
    chk("aw_hold", last_addr, 6'h00);
    aw_ready = 1'b1; aw_addr = 6'h14;
    nxt();
    chk("aw_load", last_addr, 6'h14);
    aw_v = 1'b0; aw_addr = 6'h05;
    nxt();
    chk("aw_idle", last_addr, 6'h14);

    // random traffic against the reference
    reset = 1'b1; in_v = 4'h0;
    nxt(); nxt();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_n[k] = 0; m_len[k] = 1; m_mode[k] = 2'd0; m_pend[k] = 1'b0; m_val[k] = 32'd0; m_cnt[k] = 32'd0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        in_data[i] = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : $urandom;
        in_v[i] = ($urandom_range(0, 3) != 0);
      end
      out_ready = 2'($urandom_range(0, 3));
      mode = 2'($urandom_range(0, 3));
      accum_len = 8'($urandom_range(0, 3));
      #1;
      for (int k = 0; k < 2; k++) begin
        logic [1:0] cm;
        int         cl;
        logic       allv, last, acc;
        cm   = (m_n[k] == 0) ? mode : m_mode[k];
        cl   = (m_n[k] == 0) ? ((accum_len == 8'd0) ? 1 : int'(accum_len)) : m_len[k];
        allv = in_v[2*k] && in_v[2*k+1];
        last = (m_n[k] == cl - 1);
        acc  = allv && (!m_pend[k] || out_ready[k] || !last);
        chk($sformatf("rnd%0d_l%0d_yumi", cyc, k), in_yumi[2*k +: 2], acc ? 2'b11 : 2'b00);
        chk($sformatf("rnd%0d_l%0d_out_v", cyc, k), out_v[k], m_pend[k]);
        if (m_pend[k]) chk($sformatf("rnd%0d_l%0d_data", cyc, k), out_data[k], m_val[k]);
        chk($sformatf("rnd%0d_l%0d_cnt", cyc, k), beat_cnt[k], m_cnt[k]);
        if (m_pend[k] && out_ready[k]) begin
          m_pend[k] = 1'b0;
          m_cnt[k]  = m_cnt[k] + 32'd1;
        end
        if (acc) begin
          if (m_n[k] == 0) begin
            m_mode[k] = cm;
            m_len[k]  = cl;
          end
          ga[k][m_n[k]] = in_data[2*k];
          gb[k][m_n[k]] = in_data[2*k+1];
          m_n[k]++;
          if (m_n[k] == m_len[k]) begin
            m_val[k]  = group_result(k);
            m_pend[k] = 1'b1;
            m_n[k]    = 0;
          end
        end
      end
      nxt();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
